tw_const_mul: RTL and testbench

- Sits directly downstream of the stage-twiddle ROM in the R16 BFFT datapath.
- Takes the ROM's 128-bit twiddle word (two packed 64-bit lanes) and its 128-bit per-stage constant.
- Produces the lane-wise modular product mod p = 2^64 - 2^32 + 1 through a 3-stage pipeline with valid/ready flow control.
- Tags every 16th product as the last of a radix-16 group for the butterfly.

---
 rtl/tw_pkg.sv | 21 ++
 rtl/gl_mul_lane.sv | 53 +++++
 rtl/tw_const_mul.sv | 106 ++++++++++
 tb/tb_tw_const_mul.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// Shared constants and lane/pair types for the Goldilocks twiddle multiplier.
package tw_pkg;

   localparam int unsigned LANE_W    = 64;
   localparam int unsigned P_WIDTH   = 2 * LANE_W;
   localparam int unsigned HALF_W    = LANE_W / 2;
   localparam int unsigned GROUP_LEN = 16;
   localparam int unsigned GRP_W     = $clog2(GROUP_LEN);

   // p = 2^64 - 2^32 + 1 and 2^64 mod p
   localparam logic [LANE_W-1:0] MOD_P = 64'hFFFFFFFF00000001;
   localparam logic [LANE_W-1:0] EPS   = 64'h00000000FFFFFFFF;

   typedef logic [LANE_W-1:0] lane_t;

   typedef struct packed {
      lane_t l1;
      lane_t l0;
   } pair_t;

endpackage

// File: rtl/gl_mul_lane.sv
// One lane of the 3-stage multiply / reduce-mod-p datapath; all stages share enable en.
module gl_mul_lane
   import tw_pkg::*;
(
   input  logic  CLK,
   input  logic  rst_n,
   input  logic  en,
   input  lane_t a,
   input  lane_t b,
   output lane_t r
);

   localparam int unsigned X_W = 2 * LANE_W;

   logic [X_W-1:0]    x_q, x_d;
   lane_t             t0_q, t0_d;
   lane_t             t1_q, t1_d;
   lane_t             r_q, r_d;
   logic [HALF_W-1:0] c, d;
   logic [LANE_W:0]   diff;
   logic [LANE_W:0]   s;

   // S1 full product, S2 fold of the high word, S3 final sum with one conditional subtract
   always_comb begin
      x_d  = X_W'(a) * X_W'(b);
      c    = x_q[X_W-1 -: HALF_W];
      d    = x_q[LANE_W +: HALF_W];
      diff = {1'b0, x_q[LANE_W-1:0]} - (LANE_W+1)'(c);
      t0_d = diff[LANE_W] ? LANE_W'(diff + {1'b0, MOD_P}) : diff[LANE_W-1:0];
      t1_d = {d, {HALF_W{1'b0}}} - LANE_W'(d);
      s    = {1'b0, t0_q} + {1'b0, t1_q};
      // s - p == s + EPS - 2^64, so the subtract is a 64-bit add of EPS
      r_d  = (s >= {1'b0, MOD_P}) ? (s[LANE_W-1:0] + EPS) : s[LANE_W-1:0];
   end

   // Pipeline registers; hold everything while en is low
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         x_q  <= '0;
         t0_q <= '0;
         t1_q <= '0;
         r_q  <= '0;
      end else if (en) begin
         x_q  <= x_d;
         t0_q <= t0_d;
         t1_q <= t1_d;
         r_q  <= r_d;
      end
   end

   assign r = r_q;

endmodule

// File: rtl/tw_const_mul.sv
// Lane-wise twiddle * constant mod p with valid/ready, global-stall pipeline and radix-16 grouping.
// Optional macro TW_CONST_MUL_RANGE_CHK_EN adds a sticky range_err flag for non-canonical inputs.
module tw_const_mul
   import tw_pkg::*;
(
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [P_WIDTH-1:0] tw_in,
   input  logic [P_WIDTH-1:0] tw_const,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] tw_out,
   output logic               out_last,
   output logic [GRP_W-1:0]   grp_cnt
`ifdef TW_CONST_MUL_RANGE_CHK_EN
   ,
   output logic               range_err
`endif
);

   pair_t            a_p, b_p, r_p;
   logic             adv;
   logic             v1_q, v1_d;
   logic             v2_q, v2_d;
   logic             v3_q, v3_d;
   logic [GRP_W-1:0] grp_q, grp_d;

   assign a_p = tw_in;
   assign b_p = tw_const;
   assign adv = ~v3_q | out_ready;

   gl_mul_lane u_lane0 (
      .CLK   (CLK),
      .rst_n (rst_n),
      .en    (adv),
      .a     (a_p.l0),
      .b     (b_p.l0),
      .r     (r_p.l0)
   );

   gl_mul_lane u_lane1 (
      .CLK   (CLK),
      .rst_n (rst_n),
      .en    (adv),
      .a     (a_p.l1),
      .b     (b_p.l1),
      .r     (r_p.l1)
   );

   // Valid bits shift together with the lane data; group counter steps on output transfers
   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      if (adv) begin
         v1_d = in_valid;
         v2_d = v1_q;
         v3_d = v2_q;
      end
      grp_d = grp_q + GRP_W'(v3_q & out_ready);
   end

   // Valid and group-count registers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         grp_q <= '0;
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         v3_q  <= v3_d;
         grp_q <= grp_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = v3_q;
   assign tw_out    = r_p;
   assign grp_cnt   = grp_q;
   assign out_last  = v3_q & (grp_q == GRP_W'(GROUP_LEN - 1));

`ifdef TW_CONST_MUL_RANGE_CHK_EN
   logic range_err_q, range_err_d;
   logic in_oor;

   // Sticky flag for any accepted lane outside [0, p-1]
   always_comb begin
      in_oor      = (a_p.l0 >= MOD_P) | (a_p.l1 >= MOD_P) |
                    (b_p.l0 >= MOD_P) | (b_p.l1 >= MOD_P);
      range_err_d = range_err_q | (in_valid & adv & in_oor);
   end

   // Range error register, cleared only by reset
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) range_err_q <= 1'b0;
      else        range_err_q <= range_err_d;
   end

   assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_tw_const_mul.sv
// Scoreboard bench for tw_const_mul: random and directed stimulus against a plain mod-p model.
module tb_tw_const_mul;
   import tw_pkg::*;

   localparam logic [63:0] P = 64'hFFFFFFFF00000001;

   logic               CLK = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [P_WIDTH-1:0] tw_in = '0;
   logic [P_WIDTH-1:0] tw_const = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [P_WIDTH-1:0] tw_out;
   logic               out_last;
   logic [GRP_W-1:0]   grp_cnt;
`ifdef TW_CONST_MUL_RANGE_CHK_EN
   logic               range_err;
   bit                 exp_rerr = 1'b0;
`endif

   tw_const_mul dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tw_in     (tw_in),
      .tw_const  (tw_const),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tw_out    (tw_out),
      .out_last  (out_last),
      .grp_cnt   (grp_cnt)
`ifdef TW_CONST_MUL_RANGE_CHK_EN
      ,
      .range_err (range_err)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] data;
      int           stamp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   out_idx = 0;
   bit   chk_lat = 1'b1;
   bit   rnd_rdy = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: each lane is (a*b) mod p using wide integer arithmetic
   function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] pr;
      logic [127:0] r;
      r = '0;
      for (int l = 0; l < 2; l++) begin
         pr = {64'b0, a[64*l +: 64]} * {64'b0, b[64*l +: 64]};
         pr = pr % {64'b0, P};
         r[64*l +: 64] = pr[63:0];
      end
      return r;
   endfunction

   function automatic logic [63:0] rand_lane();
      logic [63:0] v;
      case ($urandom_range(0, 9))
         0:       v = P - 64'd1;
         1:       v = 64'd0;
         2:       v = 64'h0000_0001_0000_0000;
         3:       v = 64'hFFFF_FFFF_0000_0000;
         default: begin
            v = {$urandom, $urandom};
            if (v >= P) v = v - P;
         end
      endcase
      return v;
   endfunction

   // Input side: every accepted input pushes its expected product
   always @(negedge CLK) begin
      exp_t e;
      if (rst_n) begin
`ifdef TW_CONST_MUL_RANGE_CHK_EN
         chk("range_err", 128'(range_err), 128'(exp_rerr));
`endif
         if (in_valid && in_ready) begin
            e.data  = ref_mul(tw_in, tw_const);
            e.stamp = cyc;
            sb.push_back(e);
`ifdef TW_CONST_MUL_RANGE_CHK_EN
            if (tw_in[127:64] >= P || tw_in[63:0] >= P ||
                tw_const[127:64] >= P || tw_const[63:0] >= P)
               exp_rerr = 1'b1;
`endif
         end
      end
   end

   // Output side: compare grouping every cycle and data on each output transfer
   always @(negedge CLK) begin
      exp_t e;
      int   g;
      if (rst_n) begin
         g = out_idx % GROUP_LEN;
         chk("grp_cnt", 128'(grp_cnt), 128'(g));
         chk("out_last", 128'(out_last), 128'(out_valid && (g == GROUP_LEN - 1)));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_output: got %h expected none", tw_out);
            end else begin
               e = sb.pop_front();
               chk("tw_out", tw_out, e.data);
               if (chk_lat) chk("latency", 128'(cyc - e.stamp), 128'(3));
            end
            out_idx++;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [127:0] a, input logic [127:0] b);
      bit acc;
      int n;
      in_valid = 1'b1;
      tw_in    = a;
      tw_const = b;
      n        = 0;
      do begin
         @(negedge CLK);
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 500);
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 500 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input int bubble_pct);
      while ($urandom_range(0, 99) < bubble_pct) tick();
      send({rand_lane(), rand_lane()}, {rand_lane(), rand_lane()});
   endtask

   task automatic drain();
      int k;
      in_valid  = 1'b0;
      rnd_rdy   = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while ((sb.size() != 0 || out_valid) && k < 200) begin
         tick();
         k++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d results pending expected 0", sb.size());
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held;
      int           k;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_tw_out", tw_out, 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_grp_cnt", 128'(grp_cnt), 128'(0));
`ifdef TW_CONST_MUL_RANGE_CHK_EN
      chk("rst_range_err", 128'(range_err), 128'(0));
`endif
      rst_n = 1'b1;
      tick();
      chk("in_ready_after_rst", 128'(in_ready), 128'(1));

      // Basic product and modular wrap cases
      send({64'd1, 64'd1}, {64'd2, 64'd3});
      drain();
      send({P - 64'd1, 64'h0000_0001_0000_0000}, {P - 64'd1, 64'h0000_0001_0000_0000});
      send({64'd12345, P - 64'd1}, {P - 64'd2, 64'd2});
      drain();

      // Stall with a full pipeline
      chk_lat = 1'b0;
      repeat (3) send_rand(0);
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      chk("stall_first_valid", 128'(out_valid), 128'(1));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tw_in     = {rand_lane(), rand_lane()};
      tw_const  = {rand_lane(), rand_lane()};
      held      = tw_out;
      repeat (4) begin
         @(negedge CLK);
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         chk("stall_tw_out", tw_out, held);
         chk("stall_out_valid", 128'(out_valid), 128'(1));
         tick();
      end
      out_ready = 1'b1;
      send(tw_in, tw_const);
      send_rand(0);
      drain();
      chk_lat = 1'b1;

      // Reset with three items in flight
      repeat (3) send_rand(0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_grp_cnt", 128'(grp_cnt), 128'(0));
      chk("midrst_out_last", 128'(out_last), 128'(0));
      sb.delete();
      out_idx = 0;
`ifdef TW_CONST_MUL_RANGE_CHK_EN
      exp_rerr = 1'b0;
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Grouping: 40 inputs with random bubbles
      for (int i = 0; i < 40; i++) send_rand(30);
      drain();
      chk("group_out_count", 128'(out_idx), 128'(40));
      chk("group_grp_cnt_end", 128'(grp_cnt), 128'(40 % GROUP_LEN));

      // Random bubbles and random backpressure
      chk_lat = 1'b0;
      rnd_rdy = 1'b1;
      for (int i = 0; i < 80; i++) send_rand(25);
      drain();
      chk_lat = 1'b1;

`ifdef TW_CONST_MUL_RANGE_CHK_EN
      // Non-canonical input sets the sticky flag; only reset clears it
      send({P, 64'd5}, {64'd7, 64'd9});
      chk("range_err_set", 128'(range_err), 128'(1));
      repeat (3) tick();
      chk("range_err_sticky", 128'(range_err), 128'(1));
      drain();
      chk("range_err_hold", 128'(range_err), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("range_err_rst", 128'(range_err), 128'(0));
      sb.delete();
      out_idx  = 0;
      exp_rerr = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
